// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B4 arbiter that shares one slave port
// between NUM_MASTERS masters. A grant is held for the whole cyc assertion,
// so classic and cti/bte bursts pass through unbroken. Every grant is
// followed by at least one IDLE cycle. The priority pointer then moves to
// the master after the one just served.
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wbm_*_i                master requests, master i at slice [i*W +: W]
//   wbm_dat_o              slave read data replicated into every slice
//   wbm_ack/err/rty_o      responses, routed to the granted master only
//   wbs_*_o                request fields and cyc/stb of the granted master
//   wbs_*_i                slave response
//   grant_o                one-hot current grant, 0 when idle
//
// Optional feature: define WB_RR_ARBITER_TIMEOUT_EN to add a watchdog.
// The watchdog answers a slave that stalls for TIMEOUT strobed cycles with a
// single-cycle err. It then forces wbs_cyc_o low until the master releases
// cyc.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_n_i,
   input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]      wbm_we_i,
   input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
   output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
   output logic [NUM_MASTERS-1:0]      wbm_ack_o,
   output logic [NUM_MASTERS-1:0]      wbm_err_o,
   output logic [NUM_MASTERS-1:0]      wbm_rty_o,
   output logic [AW-1:0]               wbs_adr_o,
   output logic [DW-1:0]               wbs_dat_o,
   output logic [DW/8-1:0]             wbs_sel_o,
   output logic                        wbs_we_o,
   output logic                        wbs_cyc_o,
   output logic                        wbs_stb_o,
   output logic [2:0]                  wbs_cti_o,
   output logic [1:0]                  wbs_bte_o,
   input  logic [DW-1:0]               wbs_dat_i,
   input  logic                        wbs_ack_i,
   input  logic                        wbs_err_i,
   input  logic                        wbs_rty_i,
   output logic [NUM_MASTERS-1:0]      grant_o
);

   localparam int SW = DW / 8;
   localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          gidx_q, gidx_d;   // index of granted master, 0 when idle
   logic [PW-1:0]          ptr_q, ptr_d;     // round-robin priority pointer

   logic                   in_grant;
   logic                   cyc_g;
   logic                   stb_g;
   logic                   hung;             // watchdog fired, slave cut off
   logic                   to_fire;          // watchdog err pulse this cycle

   // Round-robin pick: first requester at or after ptr_q, wrapping.
   logic [PW-1:0]          win_idx;
   logic                   found;
   logic [PW:0]            cand;

   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(k);
         if (cand >= (PW+1)'(NUM_MASTERS)) begin
            cand = cand - (PW+1)'(NUM_MASTERS);
         end
         if (!found && wbm_cyc_i[cand[PW-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[PW-1:0];
         end
      end
   end

   assign in_grant = (state_q == GRANT);
   assign cyc_g    = wbm_cyc_i[gidx_q];
   assign stb_g    = wbm_stb_i[gidx_q];

   // Next-state logic
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|wbm_cyc_i) begin
               state_d          = GRANT;
               gidx_d           = win_idx;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
            end
         end
         GRANT: begin
            if (!cyc_g) begin
               state_d = IDLE;
               grant_d = '0;
               gidx_d  = '0;
               ptr_d   = (gidx_q == PW'(NUM_MASTERS-1)) ? '0 : gidx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          hung_q, hung_d;
   logic          stalled;

   assign stalled = wbs_stb_o & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
   // cnt_q holds the stalled cycles already elapsed, so the err lands in
   // the TIMEOUT-th stalled cycle itself.
   assign to_fire = in_grant & stalled & (cnt_q == CW'(TIMEOUT - 1));
   assign hung    = hung_q;

   always_comb begin
      cnt_d  = cnt_q;
      hung_d = hung_q | to_fire;
      if (state_d != GRANT || !in_grant) begin
         cnt_d  = '0;
         hung_d = 1'b0;
      end else if (wbs_ack_i | wbs_err_i | wbs_rty_i) begin
         cnt_d = '0;
      end else if (stalled) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         cnt_q  <= '0;
         hung_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hung_q <= hung_d;
      end
   end
`else
   // No watchdog: a silent slave simply stalls the granted master.
   assign hung    = (TIMEOUT < 0);
   assign to_fire = 1'b0;
`endif

   // Request side: gidx_q is 0 when idle, so master 0 drives the fields.
   assign wbs_adr_o = wbm_adr_i[gidx_q*AW +: AW];
   assign wbs_dat_o = wbm_dat_i[gidx_q*DW +: DW];
   assign wbs_sel_o = wbm_sel_i[gidx_q*SW +: SW];
   assign wbs_cti_o = wbm_cti_i[gidx_q*3 +: 3];
   assign wbs_bte_o = wbm_bte_i[gidx_q*2 +: 2];
   assign wbs_we_o  = wbm_we_i[gidx_q];
   assign wbs_cyc_o = in_grant & cyc_g & ~hung;
   assign wbs_stb_o = wbs_cyc_o & stb_g;
   assign grant_o   = grant_q;

   // Response side
   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
         assign wbm_dat_o[gi*DW +: DW] = wbs_dat_i;
         assign wbm_ack_o[gi] = grant_q[gi] & wbs_ack_i & ~hung;
         assign wbm_err_o[gi] = grant_q[gi] & ((wbs_err_i & ~hung) | to_fire);
         assign wbm_rty_o[gi] = grant_q[gi] & wbs_rty_i & ~hung;
      end
   endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (two masters, 32-bit bus).
// Stimulus pushes the expected slave-side transfer into a queue. A monitor
// pops one entry per slave response and compares it with the DUT outputs.
// Grant timing, reset and watchdog behaviour are checked inline.
module tb_wb_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m_adr [N];
   logic [31:0] m_dat [N];
   logic [3:0]  m_sel [N];
   logic [2:0]  m_cti [N];
   logic [1:0]  m_bte [N];
   logic [N-1:0] m_we, m_cyc, m_stb;

   logic [N*AW-1:0] wbm_adr_i;
   logic [N*DW-1:0] wbm_dat_i;
   logic [N*SW-1:0] wbm_sel_i;
   logic [N*3-1:0]  wbm_cti_i;
   logic [N*2-1:0]  wbm_bte_i;
   logic [N*DW-1:0] wbm_dat_o;
   logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
   logic [AW-1:0]   wbs_adr_o;
   logic [DW-1:0]   wbs_dat_o, wbs_dat_i;
   logic [SW-1:0]   wbs_sel_o;
   logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
   logic [2:0]      wbs_cti_o;
   logic [1:0]      wbs_bte_o;
   logic            wbs_ack_i, wbs_err_i, wbs_rty_i;
   logic            slv_ack_en;
   logic            slv_cs;

   assign wbm_adr_i = {m_adr[1], m_adr[0]};
   assign wbm_dat_i = {m_dat[1], m_dat[0]};
   assign wbm_sel_i = {m_sel[1], m_sel[0]};
   assign wbm_cti_i = {m_cti[1], m_cti[0]};
   assign wbm_bte_i = {m_bte[1], m_bte[0]};

   // Slave model: 0xE00 answers err, 0xF00 answers rty, others ack when enabled.
   assign slv_cs    = wbs_cyc_o & wbs_stb_o;
   assign wbs_err_i = slv_cs & (wbs_adr_o == 32'h0000_0E00);
   assign wbs_rty_i = slv_cs & (wbs_adr_o == 32'h0000_0F00);
   assign wbs_ack_i = slv_cs & slv_ack_en & ~wbs_err_i & ~wbs_rty_i;
   assign wbs_dat_i = wbs_adr_o ^ RD_KEY;

   wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
      .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
      .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
      .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
      .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
      .wbs_rty_i(wbs_rty_i), .grant_o(grant_o)
   );

   typedef struct packed {
      logic [1:0]  gnt;
      logic [31:0] adr;
      logic        we;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic [1:0]  bte;
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [1:0]  rty;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // kind: 0 ack, 1 err, 2 rty
   task automatic expect_xfer(input int m, input logic [31:0] adr, input logic we,
                              input logic [31:0] wdat, input logic [3:0] sel,
                              input logic [2:0] cti, input int kind);
      exp_t e;
      logic [1:0] oh;
      oh = '0;
      oh[m] = 1'b1;
      e.gnt  = oh;
      e.adr  = adr;
      e.we   = we;
      e.wdat = wdat;
      e.sel  = sel;
      e.cti  = cti;
      e.bte  = (m == 0) ? 2'b01 : 2'b10;
      e.ack  = (kind == 0) ? oh : 2'b00;
      e.err  = (kind == 1) ? oh : 2'b00;
      e.rty  = (kind == 2) ? oh : 2'b00;
      exp_q.push_back(e);
   endtask

   // Monitor: one slave response = one transaction.
   always @(negedge clk) begin
      if (wbs_cyc_o && wbs_stb_o && (wbs_ack_i || wbs_err_i || wbs_rty_i)) begin
         $display("xfer gnt=%b adr=%h we=%b wdat=%h cti=%b ack=%b err=%b rty=%b",
                  grant_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_cti_o,
                  wbm_ack_o, wbm_err_o, wbm_rty_o);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer: actual=adr 0x%0h required=no transfer", wbs_adr_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_grant", grant_o, e.gnt);
            chk("mon_adr", wbs_adr_o, e.adr);
            chk("mon_we", wbs_we_o, e.we);
            chk("mon_wdat", wbs_dat_o, e.wdat);
            chk("mon_sel", wbs_sel_o, e.sel);
            chk("mon_cti", wbs_cti_o, e.cti);
            chk("mon_bte", wbs_bte_o, e.bte);
            chk("mon_ack", wbm_ack_o, e.ack);
            chk("mon_err", wbm_err_o, e.err);
            chk("mon_rty", wbm_rty_o, e.rty);
            chk("mon_rdata", wbm_dat_o, {2{e.adr ^ RD_KEY}});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Master transactor: single transfer or incrementing burst.
   task automatic xfer(input int m, input logic [31:0] adr, input logic we,
                       input logic [31:0] dat, input logic [3:0] sel, input int beats);
      int n;
      m_adr[m] = adr;
      m_dat[m] = dat;
      m_sel[m] = sel;
      m_we[m]  = we;
      m_cti[m] = (beats > 1) ? 3'b010 : 3'b000;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
      for (int b = 0; b < beats; b++) begin
         n = 0;
         #1;
         while (!(wbm_ack_o[m] | wbm_err_o[m] | wbm_rty_o[m]) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
         end
         if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL resp_wait_m%0d: actual=no response required=response within 100 cycles", m);
            break;
         end
         @(posedge clk);
         #1;
         if (b < beats - 1) begin
            m_adr[m] = m_adr[m] + 32'd4;
            if (b + 1 == beats - 1) m_cti[m] = 3'b111;
         end
      end
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
      m_cti[m] = 3'b000;
   endtask

   // Checks grant_o once per cycle; entry i (bits [2i+1:2i]) is cycle i+1.
   task automatic watch_grant(input string name, input logic [15:0] seq, input int len);
      for (int i = 0; i < len; i++) begin
         @(posedge clk);
         #2;
         chk($sformatf("%s_c%0d", name, i + 1), grant_o, seq[2*i +: 2]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         m_adr[i] = '0;
         m_dat[i] = '0;
         m_sel[i] = '0;
         m_cti[i] = '0;
      end
      m_bte[0] = 2'b01;
      m_bte[1] = 2'b10;
      m_we  = '0;
      m_cyc = '0;
      m_stb = '0;
      slv_ack_en = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", grant_o, 2'b00);
      chk("rst_wbs_cyc", wbs_cyc_o, 1'b0);
      chk("rst_wbs_stb", wbs_stb_o, 1'b0);
      chk("rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b0);
      rst_n = 1'b1;
      tick();

      // Single read by master 1, one-cycle grant latency
      expect_xfer(1, 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, 0);
      fork
         xfer(1, 32'h10, 1'b0, 32'h0, 4'hF, 1);
         begin
            #1;
            chk("lat_c0_grant", grant_o, 2'b00);
            chk("lat_c0_cyc", wbs_cyc_o, 1'b0);
            @(posedge clk);
            #1;
            chk("lat_c1_grant", grant_o, 2'b10);
            chk("lat_c1_cyc", wbs_cyc_o, 1'b1);
         end
      join
      repeat (2) tick();

      // Simultaneous requests, pointer=0: m0 first, one IDLE cycle, then m1
      expect_xfer(0, 32'h40, 1'b0, 32'h0, 4'hF, 3'b000, 0);
      expect_xfer(1, 32'h80, 1'b0, 32'h0, 4'hF, 3'b000, 0);
      fork
         xfer(0, 32'h40, 1'b0, 32'h0, 4'hF, 1);
         xfer(1, 32'h80, 1'b0, 32'h0, 4'hF, 1);
         watch_grant("contend", {2'b10, 2'b00, 2'b01, 2'b01}, 4);
      join
      repeat (2) tick();

      // 4-beat burst by m0 while m1 keeps requesting
      expect_xfer(0, 32'h100, 1'b0, 32'h0, 4'hF, 3'b010, 0);
      expect_xfer(0, 32'h104, 1'b0, 32'h0, 4'hF, 3'b010, 0);
      expect_xfer(0, 32'h108, 1'b0, 32'h0, 4'hF, 3'b010, 0);
      expect_xfer(0, 32'h10C, 1'b0, 32'h0, 4'hF, 3'b111, 0);
      expect_xfer(1, 32'h180, 1'b0, 32'h0, 4'hF, 3'b000, 0);
      fork
         xfer(0, 32'h100, 1'b0, 32'h0, 4'hF, 4);
         xfer(1, 32'h180, 1'b0, 32'h0, 4'hF, 1);
         watch_grant("burst", {2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01}, 7);
      join
      repeat (2) tick();

      // Write by m1, then err for m0, rty for m1, plain read by m0 (pointer -> 1)
      expect_xfer(1, 32'h20, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 0);
      xfer(1, 32'h20, 1'b1, 32'hDEADBEEF, 4'hF, 1);
      repeat (2) tick();
      expect_xfer(0, 32'hE00, 1'b1, 32'h1234_5678, 4'h3, 3'b000, 1);
      xfer(0, 32'hE00, 1'b1, 32'h1234_5678, 4'h3, 1);
      repeat (2) tick();
      expect_xfer(1, 32'hF00, 1'b0, 32'h0, 4'hC, 3'b000, 2);
      xfer(1, 32'hF00, 1'b0, 32'h0, 4'hC, 1);
      repeat (2) tick();
      expect_xfer(0, 32'h30, 1'b0, 32'h0, 4'hF, 3'b000, 0);
      xfer(0, 32'h30, 1'b0, 32'h0, 4'hF, 1);
      repeat (2) tick();

      // Asynchronous reset during beat 2 of an m1 burst
      expect_xfer(1, 32'h200, 1'b0, 32'h0, 4'hF, 3'b010, 0);
      expect_xfer(1, 32'h204, 1'b0, 32'h0, 4'hF, 3'b010, 0);
      m_adr[1] = 32'h200; m_we[1] = 1'b0; m_dat[1] = '0; m_sel[1] = 4'hF;
      m_cti[1] = 3'b010; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick();
      tick();
      m_adr[1] = 32'h204;
      tick();
      m_adr[1] = 32'h208;
      m_adr[0] = 32'h300; m_we[0] = 1'b0; m_dat[0] = '0; m_sel[0] = 4'hF;
      m_cti[0] = 3'b000; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_grant", grant_o, 2'b00);
      chk("arst_wbs_cyc", wbs_cyc_o, 1'b0);
      chk("arst_ack", wbm_ack_o, 2'b00);
      tick();
      chk("arst_hold_cyc", wbs_cyc_o, 1'b0);
      rst_n = 1'b1;
      expect_xfer(0, 32'h300, 1'b0, 32'h0, 4'hF, 3'b000, 0);
      expect_xfer(1, 32'h208, 1'b0, 32'h0, 4'hF, 3'b010, 0);
      tick();
      chk("post_rst_grant", grant_o, 2'b01);
      tick();
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      tick();
      chk("post_rst_idle", grant_o, 2'b00);
      tick();
      chk("post_rst_m1", grant_o, 2'b10);
      tick();
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[1] = 3'b000;
      repeat (2) tick();

`ifdef WB_RR_ARBITER_TIMEOUT_EN
      // Hung slave: err pulse in the 8th stalled cycle, cyc forced low after
      slv_ack_en = 1'b0;
      expect_xfer(1, 32'h480, 1'b0, 32'h0, 4'hF, 3'b000, 0);
      m_adr[0] = 32'h400; m_sel[0] = 4'hF; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      m_adr[1] = 32'h480; m_sel[1] = 4'hF; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 8) begin
            chk("to_err_pulse", wbm_err_o, 2'b01);
         end else begin
            chk($sformatf("to_err_c%0d", k), wbm_err_o, 2'b00);
         end
      end
      chk("to_cyc_forced", wbs_cyc_o, 1'b0);
      chk("to_grant_held", grant_o, 2'b01);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      slv_ack_en = 1'b1;
      tick();
      chk("to_idle", grant_o, 2'b00);
      tick();
      chk("to_next_grant", grant_o, 2'b10);
      tick();
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      repeat (2) tick();
`endif

      repeat (3) tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
